fifo_ms_rr: RTL and testbench
=============================

// Module: fifo_ms_rr
// PURPOSE
//  Multi-stream FIFO: one tagged write port demuxed into FLUX independent per-channel queues.
//  One shared output port drains them through a round-robin arbiter with a registered data path.
//  Successor to the single-tag multi-stream FIFO:
//  - any DEPTH, not only powers of two
//  - per-channel occupancy, almost-full flag and drop signalling
//  - fair arbitration when several channels request in the same cycle
// PARAMETERS
//  WIDTH     8      datain/dataout width; tag = datain[WIDTH-1 -: TAG_WIDTH]
//  DEPTH     4      entries per channel, >=2, any integer
//  FLUX      2      number of channels, >=2
//  AF_THRESH DEPTH-1  afull[c] asserts when count[c] >= AF_THRESH
//  (local) TAG_WIDTH = $clog2(FLUX); CNT_W = $clog2(DEPTH+1); ADDR_W = $clog2(DEPTH)
// PORTS
//  ck          in   1            clock, rising edge
//  rst_n       in   1            asynchronous reset, active-low
//  wr          in   1            write strobe; routed by tag in datain MSBs
//  datain      in   WIDTH        write data, tag included (stored unmodified)
//  wr_drop     out  1            registered 1-cycle pulse: previous-cycle write was discarded
//  rd          in   FLUX         per-channel read request, level, held until granted
//  rd_gnt      out  FLUX         combinational one-hot grant; pop happens this edge
//  full        out  FLUX         count[c]==DEPTH
//  empty       out  FLUX         count[c]==0
//  afull       out  FLUX         count[c]>=AF_THRESH
//  dataout     out  WIDTH        registered head word of the granted channel
//  dout_valid  out  1            dataout valid, 1-cycle pulse per grant
//  dout_ch     out  TAG_WIDTH    channel index of dataout
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - all pointers and counts 0; empty=all 1s; full=afull=0
//    - dataout=0, dout_valid=0, dout_ch=0, wr_drop=0
//    - rr_last=FLUX-1, so channel 0 wins first
//    - memory contents undefined
//  - Reset asserted mid-operation: every queue is emptied immediately; in-flight dout_valid is cleared.
//  - Write: wr=1, t=tag.
//    - t<FLUX and !full[t]: mem[t][wp[t]]<=datain; wp[t] advances.
//    - full[t], or t>=FLUX: word discarded, state unchanged, wr_drop=1 next cycle.
//  - Full flag is taken from the registered count. A same-cycle pop on a full channel does NOT admit the write.
//  - Pointer wrap: wp/rp go DEPTH-1 -> 0 explicitly; binary roll-over is never relied on.
//  - Arbitration:
//    - eligible[c] = rd[c] & !empty[c].
//    - Grant goes to the first eligible channel scanning rr_last+1, +2, ... modulo FLUX.
//    - At most one grant per cycle; no grant if none eligible.
//    - rr_last updates to the granted channel only when a grant occurs.
//  - Read latency 1: at the grant edge,
//    - dataout<=mem[g][rp[g]], dout_ch<=g, dout_valid<=1
//    - rp[g] advances
//  - Without a grant, dout_valid<=0 and dataout/dout_ch hold.
//  - rd on an empty channel is ignored; no fall-through (a word written at edge N is grantable from cycle N+1).
//  - Same channel written and popped in one cycle: count unchanged, both pointers advance.
//  - count[c] next = count + wr_ok[c] - pop[c]; it is never outside 0..DEPTH.
// CONFIGURATION
//  FIFO_MS_RR_CNT_EN defined:
//  - adds port cnt_flat out FLUX*CNT_W, the registered count[c] at bits [c*CNT_W +: CNT_W].
//  - Counts are updated on the same edge as the flags.
//  FIFO_MS_RR_CNT_EN undefined: the port is absent; count registers remain internal (flags unchanged).
// TESTING
//  1. Reset release, WIDTH=8 FLUX=2 DEPTH=3:
//     empty=2'b11, full=0, dout_valid=0, dataout=8'h00.
//  2. Write 8'h11, 8'h22, 8'h33 (tag 0), then 8'h44 (tag 0):
//     full[0]=1 after 3rd; 4th gives wr_drop=1 next cycle; ch1 unaffected.
//  3. DEPTH=3 wrap, 7 write/read cycles on ch0:
//     dataout order equals write order across pointer wrap; count never >3.
//  4. Both channels loaded (ch0: A0,A1; ch1: B0,B1), rd=2'b11 held:
//     dout_ch sequence 0,1,0,1; dataout A0,B0,A1,B1; dout_valid each cycle.
//  5. Full ch0, same cycle wr tag0 + rd[0]:
//     write dropped (wr_drop=1), one pop, full[0]=0 next.
//  6. rst_n low mid-stream with dout_valid=1:
//     outputs to reset values asynchronously; subsequent rd gives no grant until rewritten.

Source files
------------

// File: rtl/fifo_ms_rr_if.sv
// Bus bundle for fifo_ms_rr: tagged write port, per-channel read handshake, shared output.
// FIFO_MS_RR_CNT_EN adds the flattened per-channel occupancy bus cnt_flat.
interface fifo_ms_rr_if #(
    parameter int WIDTH = 8,
    parameter int FLUX  = 2,
    parameter int DEPTH = 4
);
    localparam int TAG_WIDTH = $clog2(FLUX);
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic                 wr;
    logic [WIDTH-1:0]     datain;
    logic                 wr_drop;
    logic [FLUX-1:0]      rd;
    logic [FLUX-1:0]      rd_gnt;
    logic [FLUX-1:0]      full;
    logic [FLUX-1:0]      empty;
    logic [FLUX-1:0]      afull;
    logic [WIDTH-1:0]     dataout;
    logic                 dout_valid;
    logic [TAG_WIDTH-1:0] dout_ch;
`ifdef FIFO_MS_RR_CNT_EN
    logic [FLUX*CNT_W-1:0] cnt_flat;

    modport master (
        output wr, datain, rd,
        input  wr_drop, rd_gnt, full, empty, afull, dataout, dout_valid, dout_ch, cnt_flat
    );
    modport slave (
        input  wr, datain, rd,
        output wr_drop, rd_gnt, full, empty, afull, dataout, dout_valid, dout_ch, cnt_flat
    );
`else
    modport master (
        output wr, datain, rd,
        input  wr_drop, rd_gnt, full, empty, afull, dataout, dout_valid, dout_ch
    );
    modport slave (
        input  wr, datain, rd,
        output wr_drop, rd_gnt, full, empty, afull, dataout, dout_valid, dout_ch
    );
`endif
endinterface

// File: rtl/fifo_ms_rr.sv
// Multi-stream FIFO: tag-routed writes into FLUX queues, round-robin drained through one registered port.
// Optional FIFO_MS_RR_CNT_EN exposes the per-channel counts on bus.cnt_flat.
module fifo_ms_rr #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int FLUX      = 2,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic          ck,
    input  logic          rst_n,
    fifo_ms_rr_if.slave   bus
);
    localparam int TAG_WIDTH = $clog2(FLUX);
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int ADDR_W    = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem   [FLUX][DEPTH];
    logic [ADDR_W-1:0]    wp    [FLUX];
    logic [ADDR_W-1:0]    rp    [FLUX];
    logic [CNT_W-1:0]     count [FLUX];
    logic [TAG_WIDTH-1:0] rr_last;

    logic [TAG_WIDTH-1:0] tag;
    logic                 tag_ok;
    logic                 target_full;
    logic                 wr_drop_nxt;
    logic [FLUX-1:0]      wr_ok;
    logic [FLUX-1:0]      eligible;
    logic [FLUX-1:0]      gnt;
    logic [TAG_WIDTH-1:0] gnt_idx;
    logic                 gnt_any;
    int                   idx;

    assign tag    = bus.datain[WIDTH-1 -: TAG_WIDTH];
    assign tag_ok = int'(tag) < FLUX;

    always_comb begin
        for (int c = 0; c < FLUX; c++) begin
            bus.full[c]  = (count[c] == CNT_W'(DEPTH));
            bus.empty[c] = (count[c] == '0);
            bus.afull[c] = (count[c] >= CNT_W'(AF_THRESH));
        end
    end

    // Write admission uses the registered full flag, so a same-cycle pop never frees room.
    always_comb begin
        target_full = 1'b0;
        wr_ok       = '0;
        for (int c = 0; c < FLUX; c++) begin
            if (tag == TAG_WIDTH'(c)) begin
                target_full = bus.full[c];
                wr_ok[c]    = bus.wr & ~bus.full[c];
            end
        end
        wr_drop_nxt = bus.wr & (~tag_ok | target_full);
    end

    assign eligible = bus.rd & ~bus.empty;

    // Scan starts just after the last winner so every requester is reached within FLUX grants.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int i = 1; i <= FLUX; i++) begin
            idx = (int'(rr_last) + i) % FLUX;
            if (!gnt_any && eligible[idx]) begin
                gnt_any      = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = TAG_WIDTH'(idx);
            end
        end
    end

    assign bus.rd_gnt = gnt;

    always_ff @(posedge ck) begin
        for (int c = 0; c < FLUX; c++) begin
            if (wr_ok[c]) begin
                mem[c][wp[c]] <= bus.datain;
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < FLUX; c++) begin
                wp[c]    <= '0;
                rp[c]    <= '0;
                count[c] <= '0;
            end
            rr_last        <= TAG_WIDTH'(FLUX - 1);
            bus.dataout    <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_ch    <= '0;
            bus.wr_drop    <= 1'b0;
        end else begin
            for (int c = 0; c < FLUX; c++) begin
                if (wr_ok[c]) begin
                    wp[c] <= (wp[c] == ADDR_W'(DEPTH - 1)) ? '0 : wp[c] + 1'b1;
                end
                if (gnt[c]) begin
                    rp[c] <= (rp[c] == ADDR_W'(DEPTH - 1)) ? '0 : rp[c] + 1'b1;
                end
                case ({wr_ok[c], gnt[c]})
                    2'b10:   count[c] <= count[c] + 1'b1;
                    2'b01:   count[c] <= count[c] - 1'b1;
                    default: count[c] <= count[c];
                endcase
            end
            bus.wr_drop    <= wr_drop_nxt;
            bus.dout_valid <= gnt_any;
            if (gnt_any) begin
                rr_last     <= gnt_idx;
                bus.dataout <= mem[gnt_idx][rp[gnt_idx]];
                bus.dout_ch <= gnt_idx;
            end
        end
    end

`ifdef FIFO_MS_RR_CNT_EN
    always_comb begin
        bus.cnt_flat = '0;
        for (int c = 0; c < FLUX; c++) begin
            bus.cnt_flat[c*CNT_W +: CNT_W] = count[c];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ms_rr.sv
// Directed bench for fifo_ms_rr (WIDTH=8, FLUX=2, DEPTH=3) with a reference queue model and output scoreboard.
// Under FIFO_MS_RR_CNT_EN the occupancy bus is compared against the model too.
module tb_fifo_ms_rr;
    localparam int WIDTH = 8;
    localparam int FLUX  = 2;
    localparam int DEPTH = 3;

    typedef struct packed {
        logic [7:0] data;
        logic       ch;
    } exp_t;

    logic ck;
    logic rst_n;

    fifo_ms_rr_if #(.WIDTH(WIDTH), .FLUX(FLUX), .DEPTH(DEPTH)) bus ();

    fifo_ms_rr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FLUX(FLUX)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int         checks;
    int         errors;
    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    exp_t       exp_q[$];
    int         rr_m;
    logic       exp_drop;
    logic       exp_valid;
    logic [7:0] last_data;
    logic       last_ch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model, check the combinational grant, then cross the edge.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic [1:0] r);
        int         sz0;
        int         sz1;
        int         g;
        logic [1:0] elig;
        logic [1:0] exp_g;
        bus.wr     = w;
        bus.datain = d;
        bus.rd     = r;
        sz0 = mq0.size();
        sz1 = mq1.size();
        exp_drop = w && ((d[7] == 1'b0) ? (sz0 == DEPTH) : (sz1 == DEPTH));
        elig = {r[1] && sz1 != 0, r[0] && sz0 != 0};
        g = -1;
        for (int i = 1; i <= FLUX; i++) begin
            int c = (rr_m + i) % FLUX;
            if (g < 0 && elig[c]) g = c;
        end
        exp_g     = 2'b00;
        exp_valid = (g >= 0);
        if (g == 0) begin
            exp_g = 2'b01;
            exp_q.push_back('{data: mq0.pop_front(), ch: 1'b0});
            rr_m = 0;
        end else if (g == 1) begin
            exp_g = 2'b10;
            exp_q.push_back('{data: mq1.pop_front(), ch: 1'b1});
            rr_m = 1;
        end
        if (w && !exp_drop) begin
            if (d[7] == 1'b0) mq0.push_back(d);
            else              mq1.push_back(d);
        end
        #1;
        check("rd_gnt", 32'(bus.rd_gnt), 32'(exp_g));
        @(posedge ck);
        #1;
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [1:0] exp_empty;
        logic [1:0] exp_full;
        logic [1:0] exp_afull;
        check("wr_drop", 32'(bus.wr_drop), 32'(exp_drop));
        check("dout_valid", 32'(bus.dout_valid), 32'(exp_valid));
        if (exp_valid) begin
            if (exp_q.size() == 0) begin
                errors++;
                $error("[TB] FAIL scoreboard_empty observed=1 expected=0");
            end else begin
                e = exp_q.pop_front();
                last_data = e.data;
                last_ch   = e.ch;
            end
        end
        check("dataout", 32'(bus.dataout), 32'(last_data));
        check("dout_ch", 32'(bus.dout_ch), 32'(last_ch));
        exp_empty = {mq1.size() == 0, mq0.size() == 0};
        exp_full  = {mq1.size() == DEPTH, mq0.size() == DEPTH};
        exp_afull = {mq1.size() >= DEPTH - 1, mq0.size() >= DEPTH - 1};
        check("empty", 32'(bus.empty), 32'(exp_empty));
        check("full", 32'(bus.full), 32'(exp_full));
        check("afull", 32'(bus.afull), 32'(exp_afull));
`ifdef FIFO_MS_RR_CNT_EN
        check("cnt_flat", 32'(bus.cnt_flat), 32'({2'(mq1.size()), 2'(mq0.size())}));
`endif
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic [1:0] r);
        applyStimulus(w, d, r);
        checkOutput();
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_empty"}, 32'(bus.empty), 32'h3);
        check({tag, "_full"}, 32'(bus.full), 32'h0);
        check({tag, "_afull"}, 32'(bus.afull), 32'h0);
        check({tag, "_dout_valid"}, 32'(bus.dout_valid), 32'h0);
        check({tag, "_dataout"}, 32'(bus.dataout), 32'h0);
        check({tag, "_dout_ch"}, 32'(bus.dout_ch), 32'h0);
        check({tag, "_wr_drop"}, 32'(bus.wr_drop), 32'h0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rr_m       = FLUX - 1;
        last_data  = 8'h00;
        last_ch    = 1'b0;
        exp_drop   = 1'b0;
        exp_valid  = 1'b0;
        bus.wr     = 1'b0;
        bus.datain = 8'h00;
        bus.rd     = 2'b00;
        rst_n      = 1'b0;

        // Reset release
        repeat (2) @(posedge ck);
        #3 rst_n = 1'b1;
        #1 checkResetState("reset");
        @(posedge ck);
        #1;

        // Fill channel 0 to DEPTH, then overflow
        step(1'b1, 8'h11, 2'b00);
        step(1'b1, 8'h22, 2'b00);
        step(1'b1, 8'h33, 2'b00);
        step(1'b1, 8'h44, 2'b00);
        step(1'b0, 8'h00, 2'b00);

        // Pointer wrap: one drain, then seven write+read cycles on channel 0
        step(1'b0, 8'h00, 2'b01);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 8'h50 + 8'(i), 2'b01);
        end

        // Full channel, same-cycle write and pop: write dropped, one pop
        step(1'b1, 8'h60, 2'b00);
        step(1'b1, 8'h61, 2'b01);
        step(1'b0, 8'h00, 2'b00);
        repeat (3) step(1'b0, 8'h00, 2'b01);
        step(1'b0, 8'h00, 2'b01);

        // Make channel 1 the last winner so the two-channel round starts at channel 0
        step(1'b1, 8'hC1, 2'b00);
        step(1'b0, 8'h00, 2'b10);

        // Round-robin across both loaded channels with rd held high
        step(1'b1, 8'h0A, 2'b00);
        step(1'b1, 8'h8B, 2'b00);
        step(1'b1, 8'h1A, 2'b00);
        step(1'b1, 8'h9B, 2'b00);
        repeat (5) step(1'b0, 8'h00, 2'b11);

        // Asynchronous reset while dout_valid is high
        step(1'b1, 8'h2D, 2'b00);
        step(1'b1, 8'h3D, 2'b00);
        step(1'b0, 8'h00, 2'b01);
        check("pre_reset_valid", 32'(bus.dout_valid), 32'h1);
        bus.wr = 1'b0;
        bus.rd = 2'b00;
        rst_n  = 1'b0;
        #1 checkResetState("async_reset");
        mq0.delete();
        mq1.delete();
        exp_q.delete();
        rr_m      = FLUX - 1;
        last_data = 8'h00;
        last_ch   = 1'b0;
        #2 rst_n = 1'b1;
        step(1'b0, 8'h00, 2'b11);
        step(1'b1, 8'h3E, 2'b00);
        step(1'b0, 8'h00, 2'b11);
        step(1'b0, 8'h00, 2'b00);

        if (exp_q.size() != 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
